fx_exp_range_reduce: RTL and testbench
======================================

# fx_exp_range_reduce

Pipelined range-reduction front end for the fixed-point exponential. Each signed fixed-point operand x is split into x = k·ln2 + r, with integer k and remainder r in [0, ln2). The remainder drives the exp LUT stage, whose fractional-MSB index is then always in range. k is passed alongside for the downstream 2^k rescale. The block sits directly upstream of the exp LUT in the discounting/payoff datapath and adds ready/valid back-pressure so the LUT feed never drops operands.

## Interface
- WIDTH, fpga_cfg_pkg::FP_WIDTH (32): operand/remainder width, two's complement.
- QINT, fpga_cfg_pkg::FP_QINT (16): integer bits of the Q format.
- QFRAC, fpga_cfg_pkg::FP_QFRAC (16): fractional bits. WIDTH = QINT + QFRAC.
- KW, 6: signed width of k.
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- valid_in  in  1  x is valid this cycle.
- ready_in  out  1  block accepts x this cycle.
- x  in  WIDTH  signed operand, Q(QINT.QFRAC).
- valid_out  out  1  r/k/ovf/unf are valid.
- ready_out  in  1  downstream accepts this cycle.
- r  out  WIDTH  remainder, Q(QINT.QFRAC), 0 ≤ r < LN2_Q.
- k  out  KW  signed exponent; result = exp(r)·2^k.
- ovf  out  1  k clamped high.
- unf  out  1  k clamped low.

## Operation
- Constants: LOG2E_Q = round(log2(e)·2^QFRAC) = 94548 (0x17154). LN2_Q = round(ln2·2^QFRAC) = 45426 (0xB172). Both use QFRAC = 16.
- S1: p = x·LOG2E_Q, a full 2·WIDTH signed product. k_raw = p >>> (2·QFRAC), an arithmetic shift, so k_raw = floor(x·log2e) including for negative x. Register x and k_raw; k_raw is held at WIDTH bits.
- S2: kl = k_raw·LN2_Q, signed and exact. r0 = x − kl. The (WIDTH+2)-bit intermediate must not wrap.
- S3, correction:
  - If r0 < 0: r = r0 + LN2_Q, k = k_raw − 1.
  - Else if r0 ≥ LN2_Q: r = r0 − LN2_Q, k = k_raw + 1.
  - Else: pass r0 and k_raw through.
  - At most one correction is needed.
- S3, clamp. K_MAX = QINT−2 (14), K_MIN = −QFRAC (−16).
  - Corrected k > K_MAX: k = K_MAX, r = LN2_Q−1, ovf = 1.
  - Corrected k < K_MIN: k = K_MIN, r = 0, unf = 1.
  - ovf and unf are never both 1.
- Transfers:
  - Input transfer occurs when valid_in & ready_in.
  - Output transfer occurs when valid_out & ready_out.
  - Order is strictly preserved.

## Timing
- Latency: exactly 3 cycles, from accepted input to valid_out, when not stalled. Throughput is 1 per cycle.
- Advance enable: en = !valid_out | ready_out. ready_in = en (combinational).
- When en = 0, all stage registers and all outputs hold, and valid_out stays 1.
- Bubbles propagate as valid = 0; they are not collapsed.
- valid_in = 1 while ready_in = 0: the operand is not consumed, and the source must hold it.
- Reset, including mid-stream: all stage valids clear asynchronously and in-flight operands are discarded. Outputs reset to valid_out = 0, r = 0, k = 0, ovf = 0, unf = 0.
- ready_in = 1 from the first cycle after rst_n deasserts.

## Structure
- fpga_cfg_pkg additions: LOG2E_Q, LN2_Q, EXP_K_W (= KW), EXP_K_MAX, EXP_K_MIN, and the typedef exp_rr_t {r, k, ovf, unf} for the downstream rescale.
- One sub-module, fx_rr_correct: the combinational S3 correction and clamp. It is tested standalone for all boundary cases.
- Multipliers map to DSP. The S1 product is registered once before the shift.

## Test plan
- x = 0x00000000 → after 3 cycles: r = 0, k = 0, ovf = unf = 0.
- x = 0x00010000 (1.0) → r = 20110 (0x4E8E), k = 1. Then x = 0xFFFF0000 (−1.0) → r = 25316 (0x62E4), k = −2. Check floor on negatives.
- x = 45426 (LN2_Q exactly) → S3 must apply the correction, giving r = 0, k = 1. Also check x = 45425 → r = 45425, k = 0.
- x = 0x7FFFFFFF → k = 14, r = 45425, ovf = 1. x = 0x80000000 → k = −16, r = 0, unf = 1.
- Stream 8 consecutive operands with ready_out held 0 for cycles 4–6:
  - ready_in must drop in the same cycles.
  - No loss and no duplication; output order matches input order.
  - valid_out and the data are stable while stalled.
- Assert rst_n = 0 with 3 operands in flight → valid_out = 0 immediately. After release, the next operand emerges with latency 3 and no stale data.

Source files
------------

// File: rtl/fpga_cfg_pkg.sv
// Shared fixed-point configuration for the exp datapath.
// Carries Q-format widths, range-reduction constants and the result record.
package fpga_cfg_pkg;

    localparam int FP_WIDTH = 32;
    localparam int FP_QINT  = 16;
    localparam int FP_QFRAC = 16;

    // round(log2(e) * 2^16) and round(ln2 * 2^16)
    localparam int LOG2E_Q   = 94548;
    localparam int LN2_Q     = 45426;

    localparam int EXP_K_W   = 6;
    localparam int EXP_K_MAX = FP_QINT - 2;
    localparam int EXP_K_MIN = -FP_QFRAC;

    typedef struct packed {
        logic [FP_WIDTH-1:0]        r;
        logic signed [EXP_K_W-1:0]  k;
        logic                       ovf;
        logic                       unf;
    } exp_rr_t;

endpackage

// File: rtl/fx_rr_correct.sv
// Final range-reduction step: folds r0 back into [0, LN2_Q) and clamps k.
// Purely combinational; no state, no flow control.
module fx_rr_correct
    import fpga_cfg_pkg::*;
#(
    parameter int W     = FP_WIDTH,
    parameter int KW    = EXP_K_W,
    parameter int K_MAX = EXP_K_MAX,
    parameter int K_MIN = EXP_K_MIN
) (
    input  logic signed [W+1:0]  r0_i,
    input  logic signed [W-1:0]  k_raw_i,
    output logic        [W-1:0]  r_o,
    output logic signed [KW-1:0] k_o,
    output logic                 ovf_o,
    output logic                 unf_o
);

    localparam logic signed [W+1:0] LN2_R = (W+2)'(LN2_Q);
    localparam logic signed [W-1:0] KMAX  = W'(K_MAX);
    localparam logic signed [W-1:0] KMIN  = W'(K_MIN);
    localparam logic signed [W-1:0] ONE   = W'(1);

    logic signed [W+1:0] r_c;
    logic signed [W-1:0] k_c;
    logic                unused_hi;

    always_comb begin
        r_c = r0_i;
        k_c = k_raw_i;
        // k_raw is off by at most one, so a single fold is sufficient
        if (r0_i[W+1]) begin
            r_c = r0_i + LN2_R;
            k_c = k_raw_i - ONE;
        end else if (r0_i >= LN2_R) begin
            r_c = r0_i - LN2_R;
            k_c = k_raw_i + ONE;
        end
    end

    always_comb begin
        r_o   = r_c[W-1:0];
        k_o   = k_c[KW-1:0];
        ovf_o = 1'b0;
        unf_o = 1'b0;
        if (k_c > KMAX) begin
            r_o   = W'(LN2_Q - 1);
            k_o   = KW'(K_MAX);
            ovf_o = 1'b1;
        end else if (k_c < KMIN) begin
            r_o   = '0;
            k_o   = KW'(K_MIN);
            unf_o = 1'b1;
        end
    end

    // Corrected r is in [0, LN2_Q) and k is narrow, so these high bits are redundant.
    assign unused_hi = ^{r_c[W+1:W], k_c[W-1:KW]};

endmodule

// File: rtl/fx_exp_range_reduce.sv
// Splits x into k*ln2 + r (0 <= r < LN2_Q) ahead of the exp LUT.
// Three register stages, 1/cycle; a single enable freezes the whole pipe on output stall.
module fx_exp_range_reduce
    import fpga_cfg_pkg::*;
#(
    parameter int WIDTH = FP_WIDTH,
    parameter int QINT  = FP_QINT,
    parameter int QFRAC = FP_QFRAC,
    parameter int KW    = EXP_K_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    valid_in,
    output logic                    ready_in,
    input  logic signed [WIDTH-1:0] x,
    output logic                    valid_out,
    input  logic                    ready_out,
    output logic        [WIDTH-1:0] r,
    output logic signed [KW-1:0]    k,
    output logic                    ovf,
    output logic                    unf
);

    localparam logic signed [2*WIDTH-1:0] LOG2E_W = (2*WIDTH)'(LOG2E_Q);
    localparam logic signed [WIDTH+1:0]   LN2_W   = (WIDTH+2)'(LN2_Q);

    logic en;

    logic                      vld1_q, vld2_q, vld3_q;
    logic signed [WIDTH-1:0]   x1_q;
    logic signed [2*WIDTH-1:0] p_d, p1_q;
    logic signed [WIDTH-1:0]   k_raw_d, k2_q;
    logic signed [WIDTH+1:0]   kl_d, r0_d, r0_q;
    logic        [WIDTH-1:0]   r_d, r_q;
    logic signed [KW-1:0]      k_d, k_q;
    logic                      ovf_d, ovf_q, unf_d, unf_q;

    assign en       = !vld3_q | ready_out;
    assign ready_in = en;

    assign p_d = (2*WIDTH)'(x) * LOG2E_W;

    // Arithmetic shift gives floor(x*log2e) for negative x as well.
    assign k_raw_d = WIDTH'(p1_q >>> (2*QFRAC));
    assign kl_d    = (WIDTH+2)'(k_raw_d) * LN2_W;
    assign r0_d    = (WIDTH+2)'(x1_q) - kl_d;

    fx_rr_correct #(
        .W     (WIDTH),
        .KW    (KW),
        .K_MAX (QINT - 2),
        .K_MIN (-QFRAC)
    ) u_correct (
        .r0_i    (r0_q),
        .k_raw_i (k2_q),
        .r_o     (r_d),
        .k_o     (k_d),
        .ovf_o   (ovf_d),
        .unf_o   (unf_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld1_q <= 1'b0;
            vld2_q <= 1'b0;
            vld3_q <= 1'b0;
            x1_q   <= '0;
            p1_q   <= '0;
            k2_q   <= '0;
            r0_q   <= '0;
            r_q    <= '0;
            k_q    <= '0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else if (en) begin
            vld1_q <= valid_in;
            x1_q   <= x;
            p1_q   <= p_d;
            vld2_q <= vld1_q;
            k2_q   <= k_raw_d;
            r0_q   <= r0_d;
            vld3_q <= vld2_q;
            r_q    <= r_d;
            k_q    <= k_d;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
        end
    end

    assign valid_out = vld3_q;
    assign r         = r_q;
    assign k         = k_q;
    assign ovf       = ovf_q;
    assign unf       = unf_q;

endmodule

// File: tb/tb_fx_exp_range_reduce.sv
// Bench for fx_exp_range_reduce: directed boundary cases, a stall stream,
// mid-stream reset and random traffic against a floor-division reference.
module tb_fx_exp_range_reduce;

    typedef struct packed {
        logic [31:0] r;
        logic [5:0]  k;
        logic        o;
        logic        u;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_in = 1'b0;
    logic        ready_in;
    logic [31:0] x_in = '0;
    logic        valid_out;
    logic        ready_out = 1'b1;
    logic [31:0] r;
    logic [5:0]  k;
    logic        ovf, unf;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t exp_q[$];

    logic        prev_stall = 1'b0;
    logic [31:0] prev_r;
    logic [5:0]  prev_k;

    always #5 clk = ~clk;

    fx_exp_range_reduce dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (valid_in),
        .ready_in  (ready_in),
        .x         (x_in),
        .valid_out (valid_out),
        .ready_out (ready_out),
        .r         (r),
        .k         (k),
        .ovf       (ovf),
        .unf       (unf)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, expv, $time);
        end
    endtask

    // Reference: the unique k with x - k*LN2 in [0, LN2), then saturate k.
    function automatic exp_t model(input logic [31:0] xv);
        longint xs, q, m;
        exp_t   e;
        xs  = longint'($signed(xv));
        q   = xs / 45426;
        m   = xs - q * 45426;
        if (m < 0) begin
            q = q - 1;
            m = m + 45426;
        end
        e.o = 1'b0;
        e.u = 1'b0;
        if (q > 14) begin
            e.r = 32'd45425; e.k = 6'd14; e.o = 1'b1;
        end else if (q < -16) begin
            e.r = 32'd0; e.k = 6'(-16); e.u = 1'b1;
        end else begin
            e.r = 32'(m); e.k = 6'(q);
        end
        return e;
    endfunction

    function automatic logic [31:0] rand_x();
        int kk;
        case ($urandom_range(0, 3))
            0:       return $urandom();
            1:       return 32'(int'($urandom_range(0, 2097152)) - 1048576);
            2: begin
                kk = int'($urandom_range(0, 40)) - 20;
                return 32'(kk * 45426 + int'($urandom_range(0, 2)) - 1);
            end
            default: return $urandom_range(0, 1) != 0 ? 32'h7FFF_FFFF - $urandom_range(0, 3)
                                                      : 32'h8000_0000 + $urandom_range(0, 3);
        endcase
    endfunction

    // Per-cycle observer, sampled mid-low-phase after drivers have settled.
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (!rst_n) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            check("ready_in_rule", ready_in, !(valid_out && !ready_out));
            if (prev_stall) begin
                check("hold_valid", valid_out, 1'b1);
                check("hold_r", r, prev_r);
                check("hold_k", k, prev_k);
            end
            if (valid_out && ready_out) begin
                check("out_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("r", r, e.r);
                    check("k", k, e.k);
                    check("ovf", ovf, e.o);
                    check("unf", unf, e.u);
                end
            end
            if (valid_in && ready_in)
                exp_q.push_back(model(x_in));
            prev_stall = valid_out && !ready_out;
            prev_r     = r;
            prev_k     = k;
        end
    end

    task automatic send_one(input int xv, input int er, input int ek, input logic eo, input logic eu);
        logic [5:0] ekv;
        int         n;
        ekv = 6'(ek);
        @(negedge clk);
        ready_out = 1'b1;
        valid_in  = 1'b1;
        x_in      = 32'(xv);
        #1 check("send_ready", ready_in, 1'b1);
        @(negedge clk);
        valid_in = 1'b0;
        x_in     = $urandom();
        n = 1;
        #1;
        while (!valid_out && n < 10) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("latency", 64'(n), 64'd3);
        check("dir_r", r, 32'(er));
        check("dir_k", k, ekv);
        check("dir_ovf", ovf, eo);
        check("dir_unf", unf, eu);
    endtask

    task automatic drain();
        int n = 0;
        @(negedge clk);
        ready_out = 1'b1;
        valid_in  = 1'b0;
        #3;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            #3;
            n++;
        end
        check("drained", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        logic [31:0] vals [8];
        int          sent;
        logic        hold;

        repeat (3) @(negedge clk);
        #1;
        check("rst_valid", valid_out, 1'b0);
        check("rst_r", r, 32'd0);
        check("rst_k", k, 6'd0);
        check("rst_flags", {ovf, unf}, 2'b00);
        rst_n = 1'b1;
        @(negedge clk);
        #1 check("ready_after_rst", ready_in, 1'b1);

        send_one(0,              0,     0,   1'b0, 1'b0);
        send_one(32'h0001_0000,  20110, 1,   1'b0, 1'b0);
        send_one(32'hFFFF_0000,  25316, -2,  1'b0, 1'b0);
        send_one(45426,          0,     1,   1'b0, 1'b0);
        send_one(45425,          45425, 0,   1'b0, 1'b0);
        send_one(32'h7FFF_FFFF,  45425, 14,  1'b1, 1'b0);
        send_one(32'h8000_0000,  0,     -16, 1'b0, 1'b1);
        send_one(635964,         0,     14,  1'b0, 1'b0);
        send_one(681390,         45425, 14,  1'b1, 1'b0);
        send_one(-726816,        0,     -16, 1'b0, 1'b0);
        send_one(-726817,        0,     -16, 1'b0, 1'b1);
        drain();

        // Eight back-to-back operands with the sink stalled for cycles 4..6.
        for (int i = 0; i < 8; i++) vals[i] = rand_x();
        sent = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            ready_out = !(i >= 4 && i <= 6);
            valid_in  = (sent < 8);
            x_in      = vals[sent % 8];
            #1;
            if (i >= 4 && i <= 6) check("stall_ready_low", ready_in, 1'b0);
            if (valid_in && ready_in) sent++;
        end
        check("stall_sent", 64'(sent), 64'd8);
        drain();

        // Reset with three operands in flight.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            ready_out = 1'b1;
            valid_in  = 1'b1;
            x_in      = rand_x();
        end
        @(negedge clk);
        valid_in = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("midrst_valid", valid_out, 1'b0);
        check("midrst_r", r, 32'd0);
        check("midrst_k", k, 6'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1 check("ready_after_midrst", ready_in, 1'b1);
        send_one(32'hFFFF_0000, 25316, -2, 1'b0, 1'b0);
        drain();

        // Random traffic with random back-pressure; source holds x until taken.
        hold = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            ready_out = ($urandom_range(0, 3) != 0);
            if (!hold) begin
                valid_in = ($urandom_range(0, 2) != 0);
                x_in     = rand_x();
            end
            #1;
            hold = valid_in && !ready_in;
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
